// File: rtl/add_result_accum_pkg.sv
// Shared types and defaults for the adder result accumulator.
package add_result_accum_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_GUARD = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/add_result_accum_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_hit flags an increment lost at max.
module add_result_accum_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat_hit
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sat_hit = inc && (cnt_q == MAX);
    assign cnt     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/add_result_accum.sv
// Accumulates a burst of {Co,S} adder results and presents the total on a valid/ready port.
//  state    | meaning
//  ST_IDLE  | registers clear, waiting for first beat of a burst
//  ST_ACCUM | mid-burst, absorbing beats until in_last
//  ST_HOLD  | total presented, input stalled until out handshake
module add_result_accum
    import add_result_accum_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int GUARD = DEF_GUARD,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int AW    = WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic             out_ovf
);

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          beat, done;
    logic [AW:0]   acc_sum;
    logic          cnt_sat, carry_sat;

    assign beat    = in_valid && in_ready_q;
    assign done    = out_valid_q && out_ready;
    // Top bit of acc_sum is the carry out of the AW-bit accumulator add.
    assign acc_sum = {1'b0, acc_q} + (AW+1)'({in_cout, in_sum});

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (beat) begin
                    acc_d   = acc_sum[AW-1:0];
                    ovf_d   = ovf_q | acc_sum[AW] | cnt_sat | carry_sat;
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (done) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d != ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    add_result_accum_sat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (beat),
        .clr     (done),
        .cnt     (out_count),
        .sat_hit (cnt_sat)
    );

    add_result_accum_sat_counter #(.CNT_W(CNT_W)) u_carry_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (beat && in_cout),
        .clr     (done),
        .cnt     (out_carry_cnt),
        .sat_hit (carry_sat)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_result_accum.sv
// Randomized bench for add_result_accum against a burst-level arithmetic model.
module tb_add_result_accum;

    localparam int WIDTH = 64;
    localparam int AW    = 72;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum = '0;
    logic             in_cout = 1'b0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [AW-1:0]    out_acc;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W-1:0] out_carry_cnt;
    logic             out_ovf;

    int total = 0;
    int bad   = 0;

    add_result_accum dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sum        (in_sum),
        .in_cout       (in_cout),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_acc       (out_acc),
        .out_count     (out_count),
        .out_carry_cnt (out_carry_cnt),
        .out_ovf       (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Burst-level model: exact wide sum, plain beat/carry tallies, a holding flag.
    logic [127:0] m_sum;
    int           m_beats, m_carries;
    bit           m_hold, m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum = '0; m_beats = 0; m_carries = 0; m_hold = 0; m_ready = 0;
        end else begin
            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 0; m_sum = '0; m_beats = 0; m_carries = 0;
                end
            end else if (m_ready && in_valid) begin
                m_sum     = m_sum + {63'd0, in_cout, in_sum};
                m_beats   = m_beats + 1;
                m_carries = m_carries + int'(in_cout);
                if (in_last) m_hold = 1;
            end
            m_ready = !m_hold;
        end
    end

    function automatic logic [AW-1:0] exp_acc();
        return m_sum[AW-1:0];
    endfunction
    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction
    function automatic bit exp_ovf();
        return ((m_sum >> AW) != 0) || (m_beats > CMAX) || (m_carries > CMAX);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_acc", out_acc, 0);
        end else begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_hold);
            if (m_hold) begin
                chk("out_acc", out_acc, exp_acc());
                chk("out_count", out_count, sat(m_beats));
                chk("out_carry_cnt", out_carry_cnt, sat(m_carries));
                chk("out_ovf", out_ovf, exp_ovf());
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle_cycles(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom);
            in_sum   = {$urandom, $urandom};
            @(posedge clk); #1;
        end
    endtask

    task automatic send_beat(input logic [63:0] s, input logic c, input logic l);
        bit acc = 0;
        in_valid = 1'b1; in_sum = s; in_cout = c; in_last = l;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(posedge clk);
            acc = in_ready;
        end
        if (!acc) chk("beat_accept_timeout", 0, 1);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain(input int stall);
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic const_burst(input int n, input logic [63:0] s, input logic c);
        for (int i = 1; i <= n; i++) send_beat(s, c, i == n);
        wait_valid();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycles(3);

        // single beat, then backpressure with refused beats
        send_beat(64'h5, 1'b0, 1'b1);
        chk("t1_valid_latency", out_valid, 1);
        chk("t1_acc", out_acc, 72'h5);
        chk("t1_count", out_count, 1);
        chk("t1_carry", out_carry_cnt, 0);
        chk("t1_ovf", out_ovf, 0);
        in_valid = 1'b1; in_sum = 64'h9; in_last = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("t3_acc_held", out_acc, 72'h5);
        chk("t3_count_held", out_count, 1);
        in_valid = 1'b0; in_last = 1'b0;
        drain(0);
        chk("t3_valid_dropped", out_valid, 0);
        chk("t3_ready_back", in_ready, 1);

        const_burst(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("t2_acc", out_acc, 72'h5_FFFF_FFFF_FFFF_FFFD);
        chk("t2_count", out_count, 3);
        chk("t2_carry", out_carry_cnt, 3);
        chk("t2_ovf", out_ovf, 0);
        drain(1);

        const_burst(300, 64'h1, 1'b0);
        chk("t4_count", out_count, 255);
        chk("t4_acc", out_acc, 72'd300);
        chk("t4_ovf", out_ovf, 1);
        drain(2);

        const_burst(255, 64'h2, 1'b0);
        chk("sat_edge255_count", out_count, 255);
        chk("sat_edge255_ovf", out_ovf, 0);
        drain(0);

        const_burst(256, 64'h2, 1'b0);
        chk("sat_edge256_ovf", out_ovf, 1);
        drain(0);

        const_burst(200, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("t5_acc", out_acc, 72'h8F_FFFF_FFFF_FFFF_FF38);
        chk("t5_ovf", out_ovf, 1);
        chk("t5_carry", out_carry_cnt, 200);
        drain(1);

        for (int b = 0; b < 30; b++) begin
            int n = $urandom_range(1, 20);
            for (int i = 1; i <= n; i++) begin
                idle_cycles($urandom_range(0, 2));
                send_beat({$urandom, $urandom}, 1'($urandom), i == n);
            end
            wait_valid();
            drain($urandom_range(0, 3));
        end

        // reset mid-burst
        send_beat(64'h10, 1'b0, 1'b0);
        send_beat(64'h10, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_acc_async", out_acc, 0);
        chk("t6_valid_async", out_valid, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        send_beat(64'h7, 1'b0, 1'b1);
        chk("t6_acc", out_acc, 72'h7);
        chk("t6_count", out_count, 1);
        drain(0);
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
